controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/aluctl.sv | 21 ++
 rtl/controller.sv | 145 ++++++++++++++
 tb/tb_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// function fields and ALU operation codes.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aluctl.sv
// R-type funct field to ALU operation decode; unknown functs fall back to add.
module aluctl
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]  funct,
  output logic [ALU_W-1:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_SUB:  alucont = ALU_SUB;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle MIPS-subset Moore controller with byte-wide instruction fetch.
// Outputs decode from the state register; only pcen also depends on zero.
module controller
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic               alusrca,
  output logic               memtoreg,
  output logic               iord,
  output logic               regwrite,
  output logic               regdst,
  output logic               pcen,
  output logic [1:0]         pcsource,
  output logic [1:0]         alusrcb,
  output logic [3:0]         irwrite,
  output logic [ALU_W-1:0]   alucont,
  output logic [STATE_W-1:0] state
);

  state_t           cur;
  state_t           nxt;
  logic [ALU_W-1:0] funct_alu;
  logic             pcwrite;
  logic             pcwritecond;

  aluctl u_aluctl (
    .funct   (funct),
    .alucont (funct_alu)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= FETCH1;
    else      cur <= nxt;
  end

  // Next-state logic; unused encodings recover to FETCH1
  always_comb begin
    nxt = FETCH1;
    case (cur)
      FETCH1:  nxt = FETCH2;
      FETCH2:  nxt = FETCH3;
      FETCH3:  nxt = FETCH4;
      FETCH4:  nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_J:         nxt = JEX;
          OP_ADDI:      nxt = ADDIEX;
          default:      nxt = FETCH1;
        endcase
      end
      MEMADR:  nxt = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    nxt = LBWR;
      LBWR:    nxt = FETCH1;
      SBWR:    nxt = FETCH1;
      RTYPEEX: nxt = RTYPEWR;
      RTYPEWR: nxt = FETCH1;
      BEQEX:   nxt = FETCH1;
      JEX:     nxt = FETCH1;
      ADDIEX:  nxt = ADDIWR;
      ADDIWR:  nxt = FETCH1;
      default: nxt = FETCH1;
    endcase
  end

  // Output decode
  always_comb begin
    memread     = 1'b0;
    memwrite    = 1'b0;
    alusrca     = 1'b0;
    memtoreg    = 1'b0;
    iord        = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 2'b00;
    alusrcb     = 2'b00;
    irwrite     = 4'b0000;
    alucont     = 3'b000;
    case (cur)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        irwrite = 4'(4'b0001 << cur[1:0]);
        alusrcb = 2'b01;
        alucont = ALU_ADD;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucont = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucont = ALU_ADD;
      end
      LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        alucont = funct_alu;
      end
      RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca     = 1'b1;
        alucont     = ALU_SUB;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JEX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
    pcen = pcwrite | (pcwritecond & zero);
  end

  assign state = cur;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the multicycle controller: walks each instruction class
// through its state sequence and checks state and every output per cycle.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
  logic [1:0] pcsource, alusrcb;
  logic [3:0] irwrite;
  logic [2:0] alucont;
  logic [3:0] state;

  int vectors = 0;
  int errors  = 0;

  controller dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .memread  (memread),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .memtoreg (memtoreg),
    .iord     (iord),
    .regwrite (regwrite),
    .regdst   (regdst),
    .pcen     (pcen),
    .pcsource (pcsource),
    .alusrcb  (alusrcb),
    .irwrite  (irwrite),
    .alucont  (alucont),
    .state    (state)
  );

  always #5 clk = ~clk;

  // {memread,memwrite,alusrca,memtoreg,iord,regwrite,regdst,pcen,pcsource,alusrcb,irwrite,alucont}
  logic [18:0] outs;
  assign outs = {memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen,
                 pcsource, alusrcb, irwrite, alucont};

  localparam logic [18:0] O_F1     = {8'b1000_0001, 2'b00, 2'b01, 4'b0001, 3'b010};
  localparam logic [18:0] O_F2     = {8'b1000_0001, 2'b00, 2'b01, 4'b0010, 3'b010};
  localparam logic [18:0] O_F3     = {8'b1000_0001, 2'b00, 2'b01, 4'b0100, 3'b010};
  localparam logic [18:0] O_F4     = {8'b1000_0001, 2'b00, 2'b01, 4'b1000, 3'b010};
  localparam logic [18:0] O_DEC    = {8'b0000_0000, 2'b00, 2'b11, 4'b0000, 3'b010};
  localparam logic [18:0] O_MEMADR = {8'b0010_0000, 2'b00, 2'b10, 4'b0000, 3'b010};
  localparam logic [18:0] O_LBRD   = {8'b1000_1000, 2'b00, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] O_LBWR   = {8'b0001_0100, 2'b00, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] O_SBWR   = {8'b0100_1000, 2'b00, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] O_RWR    = {8'b0000_0110, 2'b00, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] O_BEQ_T  = {8'b0010_0001, 2'b01, 2'b00, 4'b0000, 3'b110};
  localparam logic [18:0] O_BEQ_N  = {8'b0010_0000, 2'b01, 2'b00, 4'b0000, 3'b110};
  localparam logic [18:0] O_JEX    = {8'b0000_0001, 2'b10, 2'b00, 4'b0000, 3'b000};
  localparam logic [18:0] O_ADDIEX = {8'b0010_0000, 2'b00, 2'b10, 4'b0000, 3'b010};
  localparam logic [18:0] O_ADDIWR = {8'b0000_0100, 2'b00, 2'b00, 4'b0000, 3'b000};

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check state, outputs and the read/write exclusion
  task automatic step(input string tag, input logic [3:0] es, input logic [18:0] eo);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 19'(state), 19'(es));
    chk({tag, ".outs"}, outs, eo);
    chk({tag, ".rdwr"}, 19'(memread & memwrite), 19'(0));
  endtask

  task automatic fetch(input string tag);
    step({tag, ".f2"}, 4'd1, O_F2);
    step({tag, ".f3"}, 4'd2, O_F3);
    step({tag, ".f4"}, 4'd3, O_F4);
    step({tag, ".dec"}, 4'd4, O_DEC);
  endtask

  initial begin
    rst   = 1'b0;
    op    = 6'b100000;
    funct = 6'b000000;
    zero  = 1'b0;

    // Reset held across an edge
    @(posedge clk);
    #1;
    chk("reset.state", 19'(state), 19'(0));
    chk("reset.outs", outs, O_F1);
    @(negedge clk);
    rst = 1'b1;

    // LB: 8-cycle loop
    fetch("lb");
    step("lb.memadr", 4'd5, O_MEMADR);
    step("lb.lbrd", 4'd6, O_LBRD);
    step("lb.lbwr", 4'd7, O_LBWR);
    step("lb.f1", 4'd0, O_F1);

    // RTYPE slt
    @(negedge clk);
    op = 6'b000000; funct = 6'b101010;
    fetch("slt");
    step("slt.ex", 4'd9, {8'b0010_0000, 2'b00, 2'b00, 4'b0000, 3'b111});
    step("slt.wr", 4'd10, O_RWR);
    step("slt.f1", 4'd0, O_F1);

    // RTYPE sub, then an undefined funct
    @(negedge clk);
    funct = 6'b100010;
    fetch("sub");
    step("sub.ex", 4'd9, {8'b0010_0000, 2'b00, 2'b00, 4'b0000, 3'b110});
    step("sub.wr", 4'd10, O_RWR);
    step("sub.f1", 4'd0, O_F1);
    @(negedge clk);
    funct = 6'b111111;
    fetch("fdef");
    step("fdef.ex", 4'd9, {8'b0010_0000, 2'b00, 2'b00, 4'b0000, 3'b010});
    step("fdef.wr", 4'd10, O_RWR);
    step("fdef.f1", 4'd0, O_F1);

    // BEQ taken and not taken
    @(negedge clk);
    op = 6'b000100; zero = 1'b1;
    fetch("beqt");
    step("beqt.ex", 4'd11, O_BEQ_T);
    step("beqt.f1", 4'd0, O_F1);
    @(negedge clk);
    zero = 1'b0;
    fetch("beqn");
    step("beqn.ex", 4'd11, O_BEQ_N);
    step("beqn.f1", 4'd0, O_F1);

    // SB
    @(negedge clk);
    op = 6'b101000;
    fetch("sb");
    step("sb.memadr", 4'd5, O_MEMADR);
    step("sb.sbwr", 4'd8, O_SBWR);
    step("sb.f1", 4'd0, O_F1);

    // Illegal opcode returns straight to fetch
    @(negedge clk);
    op = 6'b111111;
    fetch("ill");
    step("ill.f1", 4'd0, O_F1);

    // J
    @(negedge clk);
    op = 6'b000010;
    fetch("j");
    step("j.jex", 4'd12, O_JEX);
    step("j.f1", 4'd0, O_F1);

    // ADDI
    @(negedge clk);
    op = 6'b001000;
    fetch("addi");
    step("addi.ex", 4'd13, O_ADDIEX);
    step("addi.wr", 4'd14, O_ADDIWR);
    step("addi.f1", 4'd0, O_F1);

    // Reset pulsed mid-LB (in LBRD)
    @(negedge clk);
    op = 6'b100000;
    fetch("lbr");
    step("lbr.memadr", 4'd5, O_MEMADR);
    step("lbr.lbrd", 4'd6, O_LBRD);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.state", 19'(state), 19'(0));
    chk("midrst.outs", outs, O_F1);
    @(posedge clk);
    #1;
    chk("midrst.hold", 19'(state), 19'(0));
    chk("midrst.wr", 19'({memwrite, regwrite}), 19'(0));
    @(negedge clk);
    rst = 1'b1;
    fetch("resume");
    step("resume.memadr", 4'd5, O_MEMADR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
